// File: rtl/ram_reader.sv
// Read-side streaming engine for the capture RAM: tracks writes, fetches words in order
// and presents them on a valid/ready stream. Optional RAM_READER_ADDR_CHECK_EN adds addr_err.
module ram_reader #(
  parameter int DATA_W = 25,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_strobe,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic              flush,
  output logic              rd_en,
  output logic [ADDR_W-1:0] read_add,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [ADDR_W:0]   avail,
  output logic              overflow
`ifdef RAM_READER_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  // IDLE: nothing fetchable | RUN: fetching | STALL: buffer full, downstream stalled | FLUSH: discard cycle
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_CNT = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              inflight, inflight_last;
  logic [1:0]        buf_cnt;
  logic [DATA_W-1:0] buf0_data, buf1_data;
  logic              buf0_last, buf1_last;

  logic              hs, occ_ok, fetch_last, inc;
  logic [ADDR_W:0]   fetchable;

  assign hs         = m_valid & m_ready;
  assign fetchable  = avail - {{(ADDR_W-1){1'b0}}, buf_cnt} - {{ADDR_W{1'b0}}, inflight};
  assign occ_ok     = (buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && !inflight);
  assign rd_en      = ((state == S_IDLE) || (state == S_RUN)) && (fetchable != '0) && occ_ok;
  assign fetch_last = (fetchable == ONE_CNT) && !wr_strobe;
  assign inc        = wr_strobe && (avail != FULL);
  assign read_add   = rd_ptr;

  // An empty buffer with a read landing this cycle presents the RAM output directly.
  assign m_valid = (buf_cnt != 2'd0) || inflight;
  assign m_data  = ((buf_cnt == 2'd0) && inflight) ? read_data : buf0_data;
  assign m_last  = ((buf_cnt == 2'd0) && inflight) ? inflight_last : buf0_last;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_FLUSH;
    end else begin
      case (state)
        S_IDLE:  if (fetchable != '0) state_next = S_RUN;
        S_RUN: begin
          if ((buf_cnt == 2'd2) && !m_ready)        state_next = S_STALL;
          else if ((fetchable == '0) && !inflight) state_next = S_IDLE;
        end
        S_STALL: if (hs) state_next = S_RUN;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      avail         <= '0;
      overflow      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_cnt       <= 2'd0;
      buf0_data     <= '0;
      buf1_data     <= '0;
      buf0_last     <= 1'b0;
      buf1_last     <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_strobe) wr_ptr <= wr_ptr + ONE_PTR;
      if (flush) begin
        // A write landing in the flush cycle is kept; the read pointer lines up with it.
        rd_ptr        <= wr_ptr;
        avail         <= {{ADDR_W{1'b0}}, wr_strobe};
        inflight      <= 1'b0;
        inflight_last <= 1'b0;
        buf_cnt       <= 2'd0;
      end else begin
        if (rd_en) rd_ptr <= rd_ptr + ONE_PTR;
        if (wr_strobe && (avail == FULL)) overflow <= 1'b1;
        avail         <= avail + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, hs};
        inflight      <= rd_en;
        inflight_last <= fetch_last;
        case (buf_cnt)
          2'd0: begin
            if (inflight && !hs) begin
              buf0_data <= read_data;
              buf0_last <= inflight_last;
              buf_cnt   <= 2'd1;
            end
          end
          2'd1: begin
            if (inflight && hs) begin
              buf0_data <= read_data;
              buf0_last <= inflight_last;
            end else if (inflight) begin
              buf1_data <= read_data;
              buf1_last <= inflight_last;
              buf_cnt   <= 2'd2;
            end else if (hs) begin
              buf_cnt <= 2'd0;
            end
          end
          default: begin
            if (hs) begin
              buf0_data <= buf1_data;
              buf0_last <= buf1_last;
              buf_cnt   <= 2'd1;
            end
          end
        endcase
      end
    end
  end

`ifdef RAM_READER_ADDR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                                 addr_err <= 1'b0;
    else if (wr_strobe && (wr_add != wr_ptr)) addr_err <= 1'b1;
  end
`else
  logic unused_wr_add;
  assign unused_wr_add = ^wr_add;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader with a behavioural synchronous-read RAM model.
// Define RAM_READER_ADDR_CHECK_EN to also exercise addr_err.
module tb_ram_reader;
  localparam int DATA_W = 25;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_add;
  logic              flush;
  logic              rd_en;
  logic [ADDR_W-1:0] read_add;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic [ADDR_W:0]   avail;
  logic              overflow;
`ifdef RAM_READER_ADDR_CHECK_EN
  logic              addr_err;
`endif

  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) mem[wr_add] <= wdata;
    if (rd_en)     read_data   <= mem[read_add];
  end

  ram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_strobe(wr_strobe), .wr_add(wr_add), .flush(flush),
    .rd_en(rd_en), .read_add(read_add), .read_data(read_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .avail(avail), .overflow(overflow)
`ifdef RAM_READER_ADDR_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_strobe = 1'b0; flush = 1'b0; m_ready = 1'b0;
    wr_add = '0; wdata = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (rd_en !== 1'b0)    begin n_err++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    n_cmp++; if (read_add !== 7'd0) begin n_err++; $display("FAIL rst_read_add: got %0d want 0", read_add); end
    n_cmp++; if (m_valid !== 1'b0)  begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 25'd0)  begin n_err++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    n_cmp++; if (m_last !== 1'b0)   begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    n_cmp++; if (avail !== 8'd0)    begin n_err++; $display("FAIL rst_avail: got %0d want 0", avail); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL idle_rd_en cycle %0d: got %b want 0", c, rd_en); end
    end
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1'b1;
    wr_strobe = 1'b1; wr_add = 7'd0; wdata = 25'h1ABCDE;
    step();
    wr_strobe = 1'b0;
    n_cmp++; if (rd_en !== 1'b1)    begin n_err++; $display("FAIL single_rd_en: got %b want 1", rd_en); end
    n_cmp++; if (read_add !== 7'd0) begin n_err++; $display("FAIL single_read_add: got %0d want 0", read_add); end
    n_cmp++; if (avail !== 8'd1)    begin n_err++; $display("FAIL single_avail1: got %0d want 1", avail); end
    n_cmp++; if (m_valid !== 1'b0)  begin n_err++; $display("FAIL single_early_valid: got %b want 0", m_valid); end
    step();
    n_cmp++; if (m_valid !== 1'b1)      begin n_err++; $display("FAIL single_m_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 25'h1ABCDE) begin n_err++; $display("FAIL single_m_data: got %h want 1abcde", m_data); end
    n_cmp++; if (m_last !== 1'b1)       begin n_err++; $display("FAIL single_m_last: got %b want 1", m_last); end
    step();
    n_cmp++; if (avail !== 8'd0)   begin n_err++; $display("FAIL single_avail0: got %0d want 0", avail); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    int fetches, pops, first_w, last_w;
    logic [DATA_W-1:0] exp_d;
    logic exp_l;
    do_reset();
    fetches = 0;
    for (int k = 0; k < 25; k++) begin
      if (k < 10) begin wr_strobe = 1'b1; wr_add = ADDR_W'(k); wdata = DATA_W'(32'h1000 + k); end
      else wr_strobe = 1'b0;
      if (rd_en) fetches++;
      if (k >= 2) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 25'h1000) begin
          n_err++; $display("FAIL burst_hold k=%0d: got valid=%b data=%h want 1/001000", k, m_valid, m_data);
        end
      end
      step();
    end
    wr_strobe = 1'b0;
    n_cmp++; if (fetches != 2)   begin n_err++; $display("FAIL burst_fetches: got %0d want 2", fetches); end
    n_cmp++; if (avail !== 8'd10) begin n_err++; $display("FAIL burst_avail: got %0d want 10", avail); end
    m_ready = 1'b1;
    pops = 0; first_w = -1; last_w = -1;
    for (int w = 0; w < 40; w++) begin
      if (m_valid) begin
        exp_d = DATA_W'(32'h1000 + pops);
        exp_l = (pops == 9);
        n_cmp++; if (m_data !== exp_d) begin n_err++; $display("FAIL burst_data %0d: got %h want %h", pops, m_data, exp_d); end
        n_cmp++; if (m_last !== exp_l) begin n_err++; $display("FAIL burst_last %0d: got %b want %b", pops, m_last, exp_l); end
        if (pops == 0) first_w = w;
        last_w = w;
        pops++;
      end
      step();
    end
    n_cmp++; if (pops != 10)           begin n_err++; $display("FAIL burst_pops: got %0d want 10", pops); end
    n_cmp++; if (last_w - first_w != 9) begin n_err++; $display("FAIL burst_rate: got span %0d want 9", last_w - first_w); end
    n_cmp++; if (avail !== 8'd0)        begin n_err++; $display("FAIL burst_drained: got %0d want 0", avail); end
  endtask

  task automatic test_overflow();
    int pops;
    logic saw127;
    logic [DATA_W-1:0] exp_d;
    logic exp_l;
    do_reset();
    for (int i = 0; i < 130; i++) begin
      wr_strobe = 1'b1; wr_add = ADDR_W'(i); wdata = DATA_W'(32'h100000 + i);
      step();
      if (i == 127) begin
        n_cmp++; if (avail !== 8'd128)  begin n_err++; $display("FAIL ovf_full_avail: got %0d want 128", avail); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      if (i == 128) begin
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
      end
    end
    wr_strobe = 1'b0;
    n_cmp++; if (avail !== 8'd128) begin n_err++; $display("FAIL ovf_sat_avail: got %0d want 128", avail); end
    m_ready = 1'b1;
    pops = 0; saw127 = 1'b0;
    for (int w = 0; w < 300; w++) begin
      if (rd_en && read_add == 7'd127) saw127 = 1'b1;
      if (m_valid) begin
        exp_d = DATA_W'(32'h100000 + pops);
        exp_l = (pops == 127);
        n_cmp++; if (m_data !== exp_d) begin n_err++; $display("FAIL ovf_data %0d: got %h want %h", pops, m_data, exp_d); end
        n_cmp++; if (m_last !== exp_l) begin n_err++; $display("FAIL ovf_last %0d: got %b want %b", pops, m_last, exp_l); end
        pops++;
      end
      step();
    end
    n_cmp++; if (pops != 128)       begin n_err++; $display("FAIL ovf_pops: got %0d want 128", pops); end
    n_cmp++; if (saw127 !== 1'b1)   begin n_err++; $display("FAIL ovf_fetch127: got %b want 1", saw127); end
    n_cmp++; if (read_add !== 7'd0) begin n_err++; $display("FAIL ovf_wrap: got %0d want 0", read_add); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    n_cmp++; if (avail !== 8'd0)    begin n_err++; $display("FAIL ovf_drained: got %0d want 0", avail); end
    do_reset();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_rst_clear: got %b want 0", overflow); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_strobe = 1'b1; wr_add = ADDR_W'(i); wdata = DATA_W'(32'h0F000 + i);
      step();
    end
    wr_strobe = 1'b0;
    step();
    n_cmp++; if (avail !== 8'd5)   begin n_err++; $display("FAIL flush_pre_avail: got %0d want 5", avail); end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", m_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (avail !== 8'd0)   begin n_err++; $display("FAIL flush_avail: got %0d want 0", avail); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    n_cmp++; if (rd_en !== 1'b0)   begin n_err++; $display("FAIL flush_rd_en: got %b want 0", rd_en); end
    m_ready = 1'b1;
    wr_strobe = 1'b1; wr_add = 7'd5; wdata = 25'h0ABCDE;
    step();
    wr_strobe = 1'b0;
    n_cmp++; if (rd_en !== 1'b1)    begin n_err++; $display("FAIL post_flush_rd_en: got %b want 1", rd_en); end
    n_cmp++; if (read_add !== 7'd5) begin n_err++; $display("FAIL post_flush_addr: got %0d want 5", read_add); end
    step();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 25'h0ABCDE || m_last !== 1'b1) begin
      n_err++; $display("FAIL post_flush_word: got v=%b d=%h l=%b want 1/0abcde/1", m_valid, m_data, m_last);
    end
    step();
    n_cmp++; if (avail !== 8'd0) begin n_err++; $display("FAIL post_flush_avail: got %0d want 0", avail); end
    // Flush with reads in flight and a write in the same cycle.
    m_ready = 1'b0;
    wr_strobe = 1'b1; wr_add = 7'd6; wdata = 25'h0666;
    step();
    wr_add = 7'd7; wdata = 25'h0777;
    step();
    flush = 1'b1; wr_add = 7'd8; wdata = 25'h1888;
    step();
    flush = 1'b0; wr_strobe = 1'b0;
    n_cmp++; if (avail !== 8'd1)   begin n_err++; $display("FAIL flushw_avail: got %0d want 1", avail); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL flushw_valid: got %b want 0", m_valid); end
    n_cmp++; if (rd_en !== 1'b0)   begin n_err++; $display("FAIL flushw_rd_en_hold: got %b want 0", rd_en); end
    step();
    n_cmp++; if (rd_en !== 1'b1 || read_add !== 7'd8) begin
      n_err++; $display("FAIL flushw_fetch: got rd_en=%b addr=%0d want 1/8", rd_en, read_add);
    end
    m_ready = 1'b1;
    step();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 25'h1888 || m_last !== 1'b1) begin
      n_err++; $display("FAIL flushw_word: got v=%b d=%h l=%b want 1/001888/1", m_valid, m_data, m_last);
    end
    step();
    n_cmp++; if (avail !== 8'd0) begin n_err++; $display("FAIL flushw_drained: got %0d want 0", avail); end
  endtask

`ifdef RAM_READER_ADDR_CHECK_EN
  task automatic test_addr_check();
    do_reset();
    m_ready = 1'b1;
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL aerr_rst: got %b want 0", addr_err); end
    for (int i = 0; i < 3; i++) begin
      wr_strobe = 1'b1; wr_add = ADDR_W'(i); wdata = DATA_W'(i);
      step();
    end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL aerr_inorder: got %b want 0", addr_err); end
    wr_add = 7'd5;
    step();
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL aerr_set: got %b want 1", addr_err); end
    wr_add = 7'd4;
    step();
    wr_strobe = 1'b0;
    repeat (3) step();
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL aerr_sticky: got %b want 1", addr_err); end
    do_reset();
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL aerr_clear: got %b want 0", addr_err); end
  endtask
`endif

  initial begin
    rst = 1'b1; wr_strobe = 1'b0; wr_add = '0; flush = 1'b0; m_ready = 1'b0; wdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_flush();
`ifdef RAM_READER_ADDR_CHECK_EN
    test_addr_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
Name: ram_reader

Overview:
- Read-side engine for the 128x25 capture RAM that the receive path fills.
- Tracks write strobes from the receive unit and issues read addresses and read enables to the RAM's synchronous read port.
- Streams the words out in order on a valid/ready interface toward the PS/AXI side, with a last-word marker and overflow detection.
- Replaces the external processor's direct read_add/rd_en polling.

Parameters:
- DATA_W, 25, RAM word width.
- ADDR_W, 7, RAM address width.
- DEPTH, 128, RAM entries; must equal 2**ADDR_W.

Ports:
- clk, in, 1, system clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_strobe, in, 1, one word written to the RAM this cycle (receive unit's sending).
- wr_add, in, ADDR_W, RAM write address accompanying wr_strobe.
- flush, in, 1, discard all unread words; one-cycle pulse.
- rd_en, out, 1, RAM read enable.
- read_add, out, ADDR_W, RAM read address.
- read_data, in, DATA_W, RAM read data; valid the cycle after rd_en.
- m_data, out, DATA_W, stream data.
- m_valid, out, 1, stream data valid.
- m_ready, in, 1, downstream accept.
- m_last, out, 1, word was the last one available when fetched.
- avail, out, ADDR_W+1, unread words held in RAM plus the output buffer.
- overflow, out, 1, sticky: write arrived while avail==DEPTH.

Behaviour:
- Reset values: rd_en=0, read_add=0, m_valid=0, m_data=0, m_last=0, avail=0, overflow=0. Internal write pointer=0, read pointer=0, FSM=IDLE.
- Counting:
  - avail increments on wr_strobe and decrements on a handshake (m_valid & m_ready).
  - Both events in the same cycle leave avail unchanged.
  - A wr_strobe at avail==DEPTH is dropped from the count and sets overflow; overflow clears only on rst.
- Pointers:
  - Read pointer wraps DEPTH-1 -> 0.
  - Internal write pointer increments on every wr_strobe, including dropped ones, and wraps the same way.
- Output buffer: 2-entry skid buffer; m_data/m_valid/m_last are driven from its head.
  - Data, once presented, holds stable until accepted.
- Fetch rule: rd_en=1 when fetchable>0 and buffer slots free minus reads in flight is >=1.
  - fetchable = avail minus words already fetched or in flight.
  - rd_en is combinational from registered state; read_add = read pointer; the pointer advances in the same cycle.
- Latency: a word written at cycle N is fetchable at N+1 (rd_en), lands in the buffer at N+2, and m_valid rises at N+2. Minimum write-to-valid is 2 cycles.
- m_last is computed at fetch: 1 if fetchable==1 and no wr_strobe in that cycle.
- FSM:
  - IDLE: fetchable==0. Go to RUN when fetchable>0.
  - RUN: issue reads per the fetch rule. Go to STALL when the buffer is full and m_ready=0. Go to IDLE when fetchable==0 and nothing is in flight.
  - STALL: rd_en=0. Return to RUN on a handshake.
  - FLUSH, entered from any state on flush:
    - avail=0, buffer cleared, m_valid=0, in-flight read data discarded, read pointer set to write pointer.
    - Lasts 1 cycle, then IDLE.
    - A wr_strobe in the flush cycle is counted after the flush and is retained.
- Stream rules: handshake = m_valid & m_ready. m_valid never depends combinationally on m_ready. Full throughput is 1 word/cycle when m_ready is held high.
- rst mid-stream: every register returns to its reset value in the next cycle; in-flight RAM data is ignored.

Optional Feature:
- Macro: RAM_READER_ADDR_CHECK_EN.
- Defined:
  - Extra output addr_err (1 bit, sticky, reset 0).
  - Set when wr_strobe=1 and wr_add != internal write pointer; the pointer is not resynchronised.
- Undefined: port absent, wr_add ignored, no comparison logic.

Test Plan:
- Reset then idle -> all outputs 0; rd_en stays 0 for 20 cycles.
- Single write of data 0x1ABCDE at addr 0, m_ready=1 -> rd_en with read_add=0 one cycle later; m_valid with m_data=0x1ABCDE and m_last=1 two cycles after the write; avail 1->0 on the handshake.
- Burst of 10 writes at addrs 0..9, m_ready low for 15 cycles, then high -> m_valid held with word 0 stable; rd_en stops after 2 fetches; then 10 consecutive words in order; m_last=1 only on word 9.
- 130 writes with m_ready=0 -> avail saturates at 128 and overflow=1 on the 129th write; read_add wraps 127->0 on later drain.
- flush asserted with avail=5 and m_valid=1 -> next cycle avail=0 and m_valid=0; a following write at the next address streams out normally.
- With RAM_READER_ADDR_CHECK_EN: wr_add=5 while the internal pointer is 3 -> addr_err=1 and it stays set until rst.
